// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer/size encodings and the AHB-to-APB bridge state type,
// reused by the bridge and by later bus components.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP,
        ST_ERR1,
        ST_ERR2
    } ahbl_apb_state_t;

    // NSEQ and SEQ carry real transfers; IDLE and BUSY get a zero-wait OKAY.
    function automatic logic htrans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahbl_to_apb.sv
// AHB-Lite slave to APB3 master bridge: one APB setup/access per AHB transfer, AHB data phase
// stretched with wait states. Optional macro APB_BRIDGE_SIZE_CHECK_EN rejects non-word transfers.
module ahbl_to_apb
    import ahb_pkg::*;
#(
    parameter int W_ADDR = 16,
    parameter int W_DATA = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              ahbls_hready,
    output logic              ahbls_hready_resp,
    output logic              ahbls_hresp,
    input  logic [31:0]       ahbls_haddr,
    input  logic              ahbls_hwrite,
    input  logic [1:0]        ahbls_htrans,
    input  logic [2:0]        ahbls_hsize,
    input  logic [W_DATA-1:0] ahbls_hwdata,
    output logic [W_DATA-1:0] ahbls_hrdata,

    output logic [W_ADDR-1:0] apbm_paddr,
    output logic              apbm_psel,
    output logic              apbm_penable,
    output logic              apbm_pwrite,
    output logic [W_DATA-1:0] apbm_pwdata,
    input  logic [W_DATA-1:0] apbm_prdata,
    input  logic              apbm_pready,
    input  logic              apbm_pslverr
);

    ahbl_apb_state_t state;
    logic            accept;
    logic            size_ok;
    logic            unused_inputs;

    assign accept = ahbls_hready && htrans_active(ahbls_htrans);

`ifdef APB_BRIDGE_SIZE_CHECK_EN
    assign size_ok = (ahbls_hsize == HSIZE_WORD);
`else
    assign size_ok = 1'b1;
`endif

    assign unused_inputs = ^{ahbls_haddr[31:W_ADDR], ahbls_hsize};

    // Every output is a register written alongside the state, so APB inputs never reach AHB outputs combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            ahbls_hready_resp <= 1'b1;
            ahbls_hresp       <= 1'b0;
            ahbls_hrdata      <= '0;
            apbm_paddr        <= '0;
            apbm_psel         <= 1'b0;
            apbm_penable      <= 1'b0;
            apbm_pwrite       <= 1'b0;
            apbm_pwdata       <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_RESP, ST_ERR2: begin
                    ahbls_hready_resp <= 1'b1;
                    ahbls_hresp       <= 1'b0;
                    state             <= ST_IDLE;
                    if (accept) begin
                        apbm_paddr        <= ahbls_haddr[W_ADDR-1:0];
                        apbm_pwrite       <= ahbls_hwrite;
                        ahbls_hready_resp <= 1'b0;
                        if (!size_ok) begin
                            state       <= ST_ERR1;
                            ahbls_hresp <= 1'b1;
                        end else if (ahbls_hwrite) begin
                            state <= ST_WDATA;
                        end else begin
                            state     <= ST_SETUP;
                            apbm_psel <= 1'b1;
                        end
                    end
                end
                ST_WDATA: begin
                    apbm_pwdata <= ahbls_hwdata;
                    apbm_psel   <= 1'b1;
                    state       <= ST_SETUP;
                end
                ST_SETUP: begin
                    apbm_penable <= 1'b1;
                    state        <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (apbm_pready) begin
                        apbm_psel    <= 1'b0;
                        apbm_penable <= 1'b0;
                        if (apbm_pslverr) begin
                            state       <= ST_ERR1;
                            ahbls_hresp <= 1'b1;
                        end else begin
                            state             <= ST_RESP;
                            ahbls_hready_resp <= 1'b1;
                            if (!apbm_pwrite) begin
                                ahbls_hrdata <= apbm_prdata;
                            end
                        end
                    end
                end
                ST_ERR1: begin
                    ahbls_hready_resp <= 1'b1;
                    ahbls_hresp       <= 1'b1;
                    state             <= ST_ERR2;
                end
                default: begin
                    state             <= ST_IDLE;
                    ahbls_hready_resp <= 1'b1;
                    ahbls_hresp       <= 1'b0;
                    apbm_psel         <= 1'b0;
                    apbm_penable      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahbl_to_apb.sv
// Directed bench for ahbl_to_apb: AHB response and APB transaction scoreboards,
// with an APB slave model that inserts configurable wait states and errors.
module tb_ahbl_to_apb;

    localparam int W_ADDR = 16;
    localparam int W_DATA = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ahbls_hready;
    logic              ahbls_hready_resp;
    logic              ahbls_hresp;
    logic [31:0]       ahbls_haddr;
    logic              ahbls_hwrite;
    logic [1:0]        ahbls_htrans;
    logic [2:0]        ahbls_hsize;
    logic [W_DATA-1:0] ahbls_hwdata;
    logic [W_DATA-1:0] ahbls_hrdata;
    logic [W_ADDR-1:0] apbm_paddr;
    logic              apbm_psel;
    logic              apbm_penable;
    logic              apbm_pwrite;
    logic [W_DATA-1:0] apbm_pwdata;
    logic [W_DATA-1:0] apbm_prdata;
    logic              apbm_pready;
    logic              apbm_pslverr;

    always #5 clk = ~clk;

    // The bridge is the only slave, so the bus-wide HREADY is its own HREADYOUT.
    assign ahbls_hready = ahbls_hready_resp;

    ahbl_to_apb #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ahbls_hready      (ahbls_hready),
        .ahbls_hready_resp (ahbls_hready_resp),
        .ahbls_hresp       (ahbls_hresp),
        .ahbls_haddr       (ahbls_haddr),
        .ahbls_hwrite      (ahbls_hwrite),
        .ahbls_htrans      (ahbls_htrans),
        .ahbls_hsize       (ahbls_hsize),
        .ahbls_hwdata      (ahbls_hwdata),
        .ahbls_hrdata      (ahbls_hrdata),
        .apbm_paddr        (apbm_paddr),
        .apbm_psel         (apbm_psel),
        .apbm_penable      (apbm_penable),
        .apbm_pwrite       (apbm_pwrite),
        .apbm_pwdata       (apbm_pwdata),
        .apbm_prdata       (apbm_prdata),
        .apbm_pready       (apbm_pready),
        .apbm_pslverr      (apbm_pslverr)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          apb_wait = 0;
    logic        apb_err  = 1'b0;
    logic [31:0] apb_rdata = '0;
    int          wait_left = 0;
    int          apb_done  = 0;
    logic [31:0] model_hrdata = '0;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
    } apb_exp_t;

    typedef struct {
        int          cycles;
        int          access;
        logic        err;
        logic [31:0] rdata;
    } ahb_exp_t;

    apb_exp_t apb_q[$];
    ahb_exp_t ahb_q[$];

    // APB slave: wait count loaded in SETUP, pready raised once it has drained in ACCESS.
    always @(posedge clk) begin
        if (apbm_psel && !apbm_penable)
            wait_left <= apb_wait;
        else if (apbm_psel && apbm_penable && wait_left > 0)
            wait_left <= wait_left - 1;
    end

    assign apbm_pready  = apbm_psel && apbm_penable && (wait_left == 0);
    assign apbm_pslverr = apbm_pready && apb_err;
    assign apbm_prdata  = apb_rdata;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // APB scoreboard: address/control/data must match the expected transfer for every psel cycle.
    always @(negedge clk) begin
        if (rst_n && apbm_psel) begin
            if (apb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $error("[TB] FAIL apb_unexpected_psel: observed paddr %h expected no transfer", apbm_paddr);
            end else begin
                check_output("paddr", 32'(apbm_paddr), apb_q[0].addr);
                check_output("pwrite", 32'(apbm_pwrite), 32'(apb_q[0].write));
                if (apb_q[0].write)
                    check_output("pwdata", apbm_pwdata, apb_q[0].wdata);
                if (apbm_penable && apbm_pready) begin
                    void'(apb_q.pop_front());
                    apb_done++;
                end
            end
        end
    end

    task automatic push_expect(input logic [31:0] addr, input logic write, input logic [2:0] size,
                               input logic [31:0] wdata);
        ahb_exp_t e;
        apb_exp_t a;
        bit       size_err;
        size_err = 1'b0;
`ifdef APB_BRIDGE_SIZE_CHECK_EN
        size_err = (size != 3'd2);
`else
        size_err = (size == 3'd7) && (size != 3'd7);
`endif
        if (size_err) begin
            e.cycles = 2;
            e.access = 0;
            e.err    = 1'b1;
        end else begin
            e.access = 1 + apb_wait;
            e.err    = apb_err;
            e.cycles = (write ? 1 : 0) + 1 + e.access + 1 + (apb_err ? 1 : 0);
            a.addr   = addr & 32'h0000_FFFF;
            a.write  = write;
            a.wdata  = wdata;
            apb_q.push_back(a);
            if (!write && !apb_err)
                model_hrdata = apb_rdata;
        end
        e.rdata = model_hrdata;
        ahb_q.push_back(e);
    endtask

    task automatic drive_addr(input logic [31:0] addr, input logic write, input logic [2:0] size,
                              input logic [31:0] wdata);
        push_expect(addr, write, size, wdata);
        ahbls_haddr  = addr;
        ahbls_hwrite = write;
        ahbls_hsize  = size;
        ahbls_htrans = 2'b10;
    endtask

    task automatic apply_stimulus(input logic [31:0] addr, input logic write, input logic [2:0] size,
                                  input logic [31:0] wdata);
        @(posedge clk);
        #1;
        drive_addr(addr, write, size, wdata);
    endtask

    // Runs one data phase; with chain set the next address phase is presented during it.
    task automatic finish_xfer(input logic [31:0] wdata, input bit chain, input logic [31:0] n_addr,
                               input logic n_write, input logic [2:0] n_size, input logic [31:0] n_wdata);
        ahb_exp_t e;
        int       cycles;
        int       setup_n;
        int       access_n;
        logic     prev_hresp;
        logic     done;
        @(posedge clk);
        #1;
        ahbls_hwdata = wdata;
        if (chain)
            drive_addr(n_addr, n_write, n_size, n_wdata);
        else
            ahbls_htrans = 2'b00;
        cycles = 0; setup_n = 0; access_n = 0; prev_hresp = 1'b0; done = 1'b0;
        while (!done && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (apbm_psel && !apbm_penable) setup_n++;
            if (apbm_psel && apbm_penable) access_n++;
            if (ahbls_hready_resp) done = 1'b1;
            else prev_hresp = ahbls_hresp;
        end
        check_output("data_phase_done", 32'(done), 32'd1);
        if (ahb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("[TB] FAIL ahb_scoreboard: observed response expected none pending");
        end else begin
            e = ahb_q.pop_front();
            check_output("data_phase_cycles", cycles, e.cycles);
            check_output("setup_cycles", setup_n, (e.access > 0) ? 1 : 0);
            check_output("access_cycles", access_n, e.access);
            check_output("hresp_final", 32'(ahbls_hresp), 32'(e.err));
            check_output("hresp_prev", 32'(prev_hresp), 32'(e.err));
            check_output("hrdata", ahbls_hrdata, e.rdata);
        end
    endtask

    initial begin
        int n0;
        logic got_access;
        rst_n        = 1'b0;
        ahbls_haddr  = '0;
        ahbls_hwrite = 1'b0;
        ahbls_htrans = 2'b00;
        ahbls_hsize  = 3'd2;
        ahbls_hwdata = '0;

        #12;
        check_output("rst_hready_resp", 32'(ahbls_hready_resp), 32'd1);
        check_output("rst_hresp", 32'(ahbls_hresp), 32'd0);
        check_output("rst_hrdata", ahbls_hrdata, 32'd0);
        check_output("rst_psel", 32'(apbm_psel), 32'd0);
        check_output("rst_penable", 32'(apbm_penable), 32'd0);
        check_output("rst_pwrite", 32'(apbm_pwrite), 32'd0);
        check_output("rst_paddr", 32'(apbm_paddr), 32'd0);
        check_output("rst_pwdata", apbm_pwdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] zero-wait read");
        apb_rdata = 32'hCAFE_F00D;
        apply_stimulus(32'h0000_0010, 1'b0, 3'd2, 32'h0);
        finish_xfer(32'h0, 1'b0, 32'h0, 1'b0, 3'd0, 32'h0);

        $display("[TB] write with two APB wait states, upper address bits ignored");
        apb_wait = 2;
        apply_stimulus(32'h4000_0024, 1'b1, 3'd2, 32'h1234_5678);
        finish_xfer(32'h1234_5678, 1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
        apb_wait = 0;

        $display("[TB] read with slave error");
        apb_err   = 1'b1;
        apb_rdata = 32'hDEAD_BEEF;
        apply_stimulus(32'h0000_0030, 1'b0, 3'd2, 32'h0);
        finish_xfer(32'h0, 1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
        apb_err = 1'b0;

        $display("[TB] back-to-back read then write");
        apb_rdata = 32'h0BAD_C0DE;
        n0 = apb_done;
        apply_stimulus(32'h0000_0040, 1'b0, 3'd2, 32'h0);
        finish_xfer(32'h0, 1'b1, 32'h0000_0044, 1'b1, 3'd2, 32'hA5A5_5A5A);
        finish_xfer(32'hA5A5_5A5A, 1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
        check_output("b2b_apb_count", apb_done - n0, 32'd2);

        $display("[TB] byte write");
        n0 = apb_done;
        apply_stimulus(32'h0000_0050, 1'b1, 3'd0, 32'h0000_0077);
        finish_xfer(32'h0000_0077, 1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
`ifdef APB_BRIDGE_SIZE_CHECK_EN
        check_output("byte_apb_count", apb_done - n0, 32'd0);
`else
        check_output("byte_apb_count", apb_done - n0, 32'd1);
`endif

        $display("[TB] reset during ACCESS");
        apb_wait  = 5;
        apb_rdata = 32'h1111_2222;
        apply_stimulus(32'h0000_0060, 1'b0, 3'd2, 32'h0);
        @(posedge clk);
        #1;
        ahbls_htrans = 2'b00;
        got_access = 1'b0;
        for (int i = 0; i < 10 && !got_access; i++) begin
            @(negedge clk);
            got_access = apbm_psel && apbm_penable;
        end
        check_output("reached_access", 32'(got_access), 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("midrst_psel", 32'(apbm_psel), 32'd0);
        check_output("midrst_penable", 32'(apbm_penable), 32'd0);
        check_output("midrst_hready_resp", 32'(ahbls_hready_resp), 32'd1);
        check_output("midrst_hresp", 32'(ahbls_hresp), 32'd0);
        check_output("midrst_hrdata", ahbls_hrdata, 32'd0);
        apb_q.delete();
        ahb_q.delete();
        model_hrdata = '0;
        apb_wait = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("post_rst_idle_hready", 32'(ahbls_hready_resp), 32'd1);
            check_output("post_rst_idle_hresp", 32'(ahbls_hresp), 32'd0);
            check_output("post_rst_idle_psel", 32'(apbm_psel), 32'd0);
        end

        $display("[TB] read after reset");
        apb_rdata = 32'h3C3C_A5A5;
        apply_stimulus(32'h0000_0070, 1'b0, 3'd2, 32'h0);
        finish_xfer(32'h0, 1'b0, 32'h0, 1'b0, 3'd0, 32'h0);

        @(negedge clk);
        check_output("apb_queue_drained", apb_q.size(), 32'd0);
        check_output("ahb_queue_drained", ahb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
